mac_layer_sequencer: RTL

- Time-multiplexes one multiplier-accumulator across N_NEURONS neurons of a binary layer.
- Latches one input vector and streams one weight row per neuron from a synchronous weight memory into the shared MAC.
- Thresholds each MAC result and returns a spike vector over a valid/ready handshake.
- Sits between the input spike source, the weight SRAM/ROM, and the externally instantiated multiplier-accumulator.

---
 rtl/mac_seq_pkg.sv | 44 ++++
 rtl/mac_layer_sequencer_neuron_update.sv | 35 +++
 rtl/mac_layer_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the binary-layer MAC sequencer: the control
// state enum, width derivations from the top-level parameters, and the
// saturating add used by the leaky-integrate membrane update.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } seq_state_e;

    // Input/weight vector width: one bit per MAC lane.
    function automatic int calc_vec_w(input int n_stage);
        return 1 << n_stage;
    endfunction

    // MAC result width: holds -2**n_stage .. +2**n_stage in two's complement.
    function automatic int calc_y_w(input int n_stage);
        return n_stage + 2;
    endfunction

    // Address width for n entries, never narrower than one bit.
    function automatic int calc_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add clamped symmetrically to +/-(2**(w-1)-1), so the most
    // negative code is never produced and the range stays sign-symmetric.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s;
        logic signed [32:0] lim;
        s   = 33'(a) + 33'(b);
        lim = (33'sd1 <<< (w - 1)) - 33'sd1;
        if (s > lim) begin
            s = lim;
        end else if (s < -lim) begin
            s = -lim;
        end
        return 32'(s);
    endfunction

endpackage

// File: rtl/mac_layer_sequencer_neuron_update.sv
// Per-neuron update for one MAC result. The default build is a stateless
// signed threshold compare; with LIF_MEMBRANE_EN defined the MAC result is
// integrated into a saturating membrane that resets to zero on firing.
module mac_neuron_update
    import mac_seq_pkg::*;
#(
    parameter int Y_W   = 8,
    parameter int MEM_W = 10,
    parameter int TH_W  = 8
) (
    input  logic signed [Y_W-1:0]   mac_y,
    input  logic signed [TH_W-1:0]  thr_q,
    input  logic signed [MEM_W-1:0] v_in,
    output logic                    fire,
    output logic signed [MEM_W-1:0] v_out
);

`ifdef LIF_MEMBRANE_EN
    logic signed [31:0] sum32;

    // Integrate, compare against the threshold, and reset the membrane on a spike.
    always_comb begin
        sum32 = sat_add(32'(v_in), 32'(mac_y), MEM_W);
        fire  = (sum32 >= 32'(thr_q));
        v_out = fire ? '0 : MEM_W'(sum32);
    end
`else
    // Plain signed compare; the membrane passes through untouched.
    always_comb begin
        fire  = (mac_y >= thr_q);
        v_out = v_in;
    end
`endif

endmodule

// File: rtl/mac_layer_sequencer.sv
// Binary-layer sequencer: latches one input vector, streams one weight row
// per neuron through an external MAC, thresholds each result into a spike
// vector and hands it out over valid/ready.
// Optional feature macro: LIF_MEMBRANE_EN (persistent per-neuron membranes).
module mac_layer_sequencer
    import mac_seq_pkg::*;
#(
    parameter  int N_STAGE   = 6,
    parameter  int N_NEURONS = 8,
    parameter  int MEM_W     = 10,
    localparam int VEC_W     = calc_vec_w(N_STAGE),
    localparam int Y_W       = calc_y_w(N_STAGE),
    localparam int AW        = calc_aw(N_NEURONS),
`ifdef LIF_MEMBRANE_EN
    localparam int TH_W      = MEM_W
`else
    localparam int TH_W      = calc_y_w(N_STAGE)
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [VEC_W-1:0]       x_data,
    input  logic signed [TH_W-1:0] thresh,
    output logic                   w_rd_en,
    output logic [AW-1:0]          w_addr,
    input  logic [VEC_W-1:0]       w_data,
    output logic [VEC_W-1:0]       mac_w,
    output logic [VEC_W-1:0]       mac_x,
    input  logic signed [Y_W-1:0]  mac_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_NEURONS-1:0]   spikes,
    output logic                   busy
);

    // cnt spans 0..N_NEURONS: N_NEURONS address-issue slots plus one drain slot.
    localparam int            CW       = calc_aw(N_NEURONS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_NEURONS);

    seq_state_e              state;
    seq_state_e              state_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_m1;
    logic [AW-1:0]           nidx;
    logic signed [TH_W-1:0]  thr_q;
    logic                    accept;
    logic                    upd_en;
    logic                    fire;
    logic signed [MEM_W-1:0] v_cur;
    logic signed [MEM_W-1:0] v_nxt;

    // The weight row arrives already aligned with the cycle that consumes it.
    assign mac_w  = w_data;
    // The row read in slot cnt-1 is on mac_y now; that is the neuron to update.
    assign cnt_m1 = cnt - CW'(1);
    assign nidx   = cnt_m1[AW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all handshake/memory-strobe outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned
        // and no latch is inferred.
        state_nxt = state;
        x_ready   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_rd_en   = 1'b0;
        w_addr    = '0;
        accept    = 1'b0;
        upd_en    = 1'b0;
        case (state)
            IDLE: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt != CNT_LAST) begin
                    w_rd_en = 1'b1;
                    w_addr  = cnt[AW-1:0];
                end
                if (cnt != '0) begin
                    upd_en = 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input latch, slot counter and spike vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mac_x  <= '0;
            thr_q  <= '0;
            spikes <= '0;
        end else begin
            if (accept) begin
                mac_x <= x_data;
                thr_q <= thresh;
                cnt   <= '0;
            end else if (state == RUN && cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end
            if (upd_en) begin
                spikes[nidx] <= fire;
            end
        end
    end

`ifdef LIF_MEMBRANE_EN
    logic signed [MEM_W-1:0] v_q [N_NEURONS];

    assign v_cur = v_q[nidx];

    // Membrane storage, written back once per neuron per pass.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is reset explicitly because a reset
        // must discard all integrated history, unlike a RAM left uninitialised.
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= '0;
            end
        end else if (upd_en) begin
            v_q[nidx] <= v_nxt;
        end
    end
`else
    // Stateless build: no membranes, and the update's membrane output has no consumer.
    logic unused_membrane;
    assign v_cur           = '0;
    assign unused_membrane = ^v_nxt;
`endif

    mac_neuron_update #(
        .Y_W   (Y_W),
        .MEM_W (MEM_W),
        .TH_W  (TH_W)
    ) u_update (
        .mac_y (mac_y),
        .thr_q (thr_q),
        .v_in  (v_cur),
        .fire  (fire),
        .v_out (v_nxt)
    );

endmodule
